iscas_bist_ctrl: RTL and testbench

- Synthesisable built-in self-test controller that exercises one ISCAS89 sequential benchmark core (s27 and larger) without a hand-written stimulus sequence.
- Drives the core's primary inputs from a parametrised Galois LFSR and runs a flush phase so core flop state settles.
- Compacts the core's primary outputs into a MISR over a fixed number of patterns, then compares the result against a golden signature.
- Sits between the benchmark core and the top-level test harness; one controller instance per core.

---
 rtl/iscas_bist_pkg.sv | 22 ++
 rtl/bist_galois_shreg.sv | 39 +++
 rtl/iscas_bist_ctrl.sv | 147 ++++++++++++++
 tb/tb_iscas_bist_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iscas_bist_pkg.sv
// Shared types and constants for the ISCAS89 BIST controller: FSM state
// encoding, default polynomials/seed and the zero-seed fix-up.
package iscas_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  localparam logic [15:0] DEF_LFSR_POLY = 16'hB400;
  localparam logic [15:0] DEF_MISR_POLY = 16'hB400;
  localparam logic [15:0] DEF_SEED      = 16'hACE1;

  // An all-zero Galois LFSR is stuck forever, so a zero seed becomes 1.
  // Works on a 64-bit container; callers cast to their own width.
  function automatic logic [63:0] nonzero_seed(input logic [63:0] seed);
    return (seed == 64'd0) ? 64'd1 : seed;
  endfunction

endpackage

// File: rtl/bist_galois_shreg.sv
// Right-shifting Galois shift register with synchronous load and a
// parallel XOR injection; serves as both the pattern LFSR and the MISR.
module bist_galois_shreg #(
  parameter int             W        = 16,
  parameter logic [W-1:0]   POLY     = '0,
  parameter logic [W-1:0]   LOAD_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] xor_in,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // load takes priority over step so a restart never mixes in old state
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = LOAD_VAL;
    end else if (step) begin
      q_d = (q_q >> 1) ^ (q_q[0] ? POLY : '0) ^ xor_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= LOAD_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/iscas_bist_ctrl.sv
// BIST controller for one ISCAS89 core: LFSR-driven primary inputs, a flush
// phase, MISR compaction of primary outputs and a golden-signature compare.
module iscas_bist_ctrl
  import iscas_bist_pkg::*;
#(
  parameter int                N_IN       = 4,
  parameter int                N_OUT      = 1,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY  = DEF_LFSR_POLY,
  parameter logic [LFSR_W-1:0] SEED       = DEF_SEED,
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] MISR_POLY  = DEF_MISR_POLY,
  parameter int                FLUSH_CYC  = 3,
  parameter int                N_PATTERNS = 256,
  parameter int                CNT_W      = 16
) (
  input  logic              CK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              abort,
  input  logic [MISR_W-1:0] golden_sig,
  input  logic [N_OUT-1:0]  cut_out,
  output logic [N_IN-1:0]   cut_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature,
  output logic [CNT_W-1:0]  pat_cnt,
  output logic [1:0]        dbg_state
);

  localparam logic [LFSR_W-1:0] SEED_FIX   = LFSR_W'(nonzero_seed(64'(SEED)));
  localparam logic [CNT_W-1:0]  FLUSH_LAST = CNT_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0]  RUN_LAST   = CNT_W'(N_PATTERNS - 1);

  bist_state_e       state_q;
  bist_state_e       state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic              lfsr_load;
  logic              lfsr_step;
  logic              misr_load;
  logic              misr_step;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_unused;
  logic [MISR_W-1:0] misr_q;
  logic [MISR_W-1:0] cut_ext;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    misr_load = 1'b0;
    misr_step = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          lfsr_load = 1'b1;
          misr_load = 1'b1;
          cnt_d     = '0;
          state_d   = (FLUSH_CYC == 0) ? ST_RUN : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // abort leaves the counter and MISR as evidence of where it stopped
        if (abort) begin
          lfsr_load = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          lfsr_step = 1'b1;
          if (cnt_q == FLUSH_LAST) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          lfsr_load = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          lfsr_step = 1'b1;
          misr_step = 1'b1;
          if (cnt_q == RUN_LAST) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  bist_galois_shreg #(
    .W        (LFSR_W),
    .POLY     (LFSR_POLY),
    .LOAD_VAL (SEED_FIX)
  ) u_lfsr (
    .clk    (CK),
    .rst_n  (RST_N),
    .load   (lfsr_load),
    .step   (lfsr_step),
    .xor_in ('0),
    .q      (lfsr_q)
  );

  assign cut_ext = MISR_W'(cut_out);

  bist_galois_shreg #(
    .W        (MISR_W),
    .POLY     (MISR_POLY),
    .LOAD_VAL ('0)
  ) u_misr (
    .clk    (CK),
    .rst_n  (RST_N),
    .load   (misr_load),
    .step   (misr_step),
    .xor_in (cut_ext),
    .q      (misr_q)
  );

  // Only the low N_IN LFSR bits reach the core; the rest is internal state.
  assign lfsr_unused = lfsr_q;
  assign cut_in      = lfsr_q[N_IN-1:0];
  assign busy        = (state_q == ST_FLUSH) || (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign pass        = done && (misr_q == golden_sig);
  assign signature   = misr_q;
  assign pat_cnt     = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_iscas_bist_ctrl.sv
// Self-checking bench for iscas_bist_ctrl: randomized start/abort/cut_out
// against a behavioural run model, plus hand-computed anchor values.
module tb_iscas_bist_ctrl;
  import iscas_bist_pkg::*;

  localparam int          F    = 3;
  localparam int          N    = 256;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] POLY = 16'hB400;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // main DUT (defaults)
  logic        start, abort;
  logic [15:0] golden_sig;
  logic        cut_out;
  logic [3:0]  cut_in;
  logic        busy, done, pass;
  logic [15:0] signature, pat_cnt;
  logic [1:0]  dbg_state;

  iscas_bist_ctrl #(
    .N_IN(4), .N_OUT(1), .LFSR_W(16), .LFSR_POLY(POLY), .SEED(SEED),
    .MISR_W(16), .MISR_POLY(POLY), .FLUSH_CYC(F), .N_PATTERNS(N), .CNT_W(16)
  ) dut (
    .CK(clk), .RST_N(rst_n), .start(start), .abort(abort),
    .golden_sig(golden_sig), .cut_out(cut_out), .cut_in(cut_in),
    .busy(busy), .done(done), .pass(pass), .signature(signature),
    .pat_cnt(pat_cnt), .dbg_state(dbg_state)
  );

  // second DUT: no flush, two patterns, output tied high
  logic        start_b, abort_b;
  logic [15:0] golden_b;
  logic [3:0]  cut_in_b;
  logic        busy_b, done_b, pass_b;
  logic [15:0] signature_b, pat_cnt_b;
  logic [1:0]  dbg_state_b;

  iscas_bist_ctrl #(.FLUSH_CYC(0), .N_PATTERNS(2)) dut_b (
    .CK(clk), .RST_N(rst_n), .start(start_b), .abort(abort_b),
    .golden_sig(golden_b), .cut_out(1'b1), .cut_in(cut_in_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .signature(signature_b),
    .pat_cnt(pat_cnt_b), .dbg_state(dbg_state_b)
  );

  // s27 core attached to the main DUT; cleared on start so runs are repeatable
  logic g5, g6, g7, g8, g9, g10, g11, g12, g13, g14, g15, g16, g17;
  always_comb begin
    g14 = ~cut_in[0];
    g12 = ~(cut_in[1] | g7);
    g8  = g14 & g6;
    g15 = g12 | g8;
    g16 = cut_in[3] | g8;
    g9  = ~(g16 & g15);
    g11 = ~(g5 | g9);
    g10 = ~(g14 | g11);
    g13 = ~(cut_in[2] | g12);
    g17 = ~g11;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     {g5, g6, g7} <= 3'b000;
    else if (start) {g5, g6, g7} <= 3'b000;
    else            {g5, g6, g7} <= {g10, g11, g13};
  end

  // cut_out source: 0 zero, 1 random, 2 s27, 3 parity of cut_in
  logic [1:0] cut_sel;
  logic       rnd_bit;
  always_comb begin
    case (cut_sel)
      2'd0:    cut_out = 1'b0;
      2'd1:    cut_out = rnd_bit;
      2'd2:    cut_out = g17;
      default: cut_out = ^cut_in;
    endcase
  end

  // scoreboard counters
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] galois(input logic [15:0] v, input logic [15:0] inj);
    return (v >> 1) ^ (v[0] ? POLY : 16'h0000) ^ inj;
  endfunction

  // behavioural model: a run is F+N steps long, the last N of which compact
  logic        s_start, s_abort, s_cut;
  logic        m_active, m_done;
  int          m_step;
  logic [15:0] m_lfsr, m_misr, m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_done <= 1'b0; m_step <= 0;
      m_lfsr <= SEED; m_misr <= 16'h0; m_cnt <= 16'h0;
    end else if (!m_active) begin
      if (s_start) begin
        m_active <= 1'b1; m_done <= 1'b0; m_step <= 0;
        m_lfsr <= SEED; m_misr <= 16'h0; m_cnt <= 16'h0;
      end
    end else if (s_abort) begin
      m_active <= 1'b0; m_done <= 1'b0; m_lfsr <= SEED;
    end else begin
      m_lfsr <= galois(m_lfsr, 16'h0000);
      if (m_step >= F) m_misr <= galois(m_misr, {15'h0, s_cut});
      if (m_step == F + N - 1) begin
        m_active <= 1'b0; m_done <= 1'b1; m_cnt <= 16'(N - 1);
      end else begin
        m_step <= m_step + 1;
        m_cnt  <= (m_step + 1 < F) ? 16'(m_step + 1) : 16'(m_step + 1 - F);
      end
    end
  end

  // compare process: inputs snapshotted and outputs checked mid-cycle
  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    s_start = start;
    s_abort = abort;
    s_cut   = cut_out;
    if (cmp_en) begin
      chk("cut_in",    32'(cut_in),    32'(m_lfsr[3:0]));
      chk("busy",      32'(busy),      32'(m_active));
      chk("done",      32'(done),      32'(m_done));
      chk("pass",      32'(pass),      32'(m_done && (m_misr == golden_sig)));
      chk("signature", 32'(signature), 32'(m_misr));
      chk("pat_cnt",   32'(pat_cnt),   32'(m_cnt));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
    rnd_bit = 1'($urandom_range(0, 1));
  endtask

  task automatic run_full();
    int n;
    n = 0;
    while (m_active && n < 2000) begin tick(); n++; end
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 1000) begin tick(); n++; end
    chk("run_done", 32'(done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] sig_ref;
  logic [3:0]  exp_seq [4];
  int          n;

  initial begin
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; golden_sig = 16'h0;
    cut_sel = 2'd0; rnd_bit = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; golden_b = 16'hB401;
    exp_seq[0] = 4'h1; exp_seq[1] = 4'h0; exp_seq[2] = 4'h8; exp_seq[3] = 4'hC;

    // reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cut_in",  32'(cut_in),    32'h1);
    chk("rst_busy",    32'(busy),      32'h0);
    chk("rst_done",    32'(done),      32'h0);
    chk("rst_pass",    32'(pass),      32'h0);
    chk("rst_sig",     32'(signature), 32'h0);
    chk("rst_pat_cnt", 32'(pat_cnt),   32'h0);
    chk("rst_state",   32'(dbg_state), 32'(ST_IDLE));
    chk("rst_cut_in_b",32'(cut_in_b),  32'h1);
    cmp_en = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // zero-output run: pattern sequence, busy length, zero signature
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 400) begin
      if (n < 4) chk("pattern_seq", 32'(cut_in), 32'(exp_seq[n]));
      n++;
      tick();
    end
    chk("busy_cycles", 32'(n),         32'd259);
    chk("zero_done",   32'(done),      32'd1);
    chk("zero_sig",    32'(signature), 32'h0);
    golden_sig = 16'h0000; #1;
    chk("pass_golden0", 32'(pass), 32'd1);
    golden_sig = 16'h0001; #1;
    chk("pass_golden1", 32'(pass), 32'd0);

    // abort in RUN at pat_cnt 5, then a fresh run reproduces the signature
    cut_sel = 2'd3;
    run_full();
    sig_ref = m_misr;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (m_step != F + 5 && n < 50) begin tick(); n++; end
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy",    32'(busy),    32'd0);
    chk("abort_done",    32'(done),    32'd0);
    chk("abort_cut_in",  32'(cut_in),  32'h1);
    chk("abort_pat_cnt", 32'(pat_cnt), 32'd5);
    tick();
    run_full();
    chk("abort_rerun_sig", 32'(signature), 32'(sig_ref));

    // randomized start/abort/cut_out traffic
    cut_sel = 2'd1;
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 30) == 0);
      abort = ($urandom_range(0, 300) == 0);
      if (i % 200 == 0) golden_sig = 16'($urandom);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;

    // asynchronous reset in the middle of RUN
    run_full();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (m_step != F + 10 && n < 50) begin tick(); n++; end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_busy",    32'(busy),      32'd0);
    chk("midrst_done",    32'(done),      32'd0);
    chk("midrst_sig",     32'(signature), 32'h0);
    chk("midrst_cut_in",  32'(cut_in),    32'h1);
    chk("midrst_pat_cnt", 32'(pat_cnt),   32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run_full();

    // s27 core: two back-to-back runs from DONE give the same signature
    cut_sel = 2'd2;
    run_full();
    sig_ref = m_misr;
    golden_sig = sig_ref;
    run_full();
    chk("s27_repeat_sig", 32'(signature), 32'(sig_ref));
    chk("s27_pass",       32'(pass),      32'd1);

    // no-flush, two-pattern instance with output tied to 1
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("b_busy_e0", 32'(busy_b),      32'd1);
    chk("b_sig_e0",  32'(signature_b), 32'h0000);
    tick();
    chk("b_sig_e1",  32'(signature_b), 32'h0001);
    chk("b_busy_e1", 32'(busy_b),      32'd1);
    chk("b_done_e1", 32'(done_b),      32'd0);
    chk("b_cnt_e1",  32'(pat_cnt_b),   32'd1);
    tick();
    chk("b_sig_e2",  32'(signature_b), 32'hB401);
    chk("b_done_e2", 32'(done_b),      32'd1);
    chk("b_busy_e2", 32'(busy_b),      32'd0);
    chk("b_cnt_e2",  32'(pat_cnt_b),   32'd1);
    chk("b_pass",    32'(pass_b),      32'd1);
    chk("b_state",   32'(dbg_state_b), 32'(ST_DONE));
    chk("b_cut_in",  32'(cut_in_b),    32'h8);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
